// File: rtl/id_ex_stage_if.sv
// Decode-to-ID/EX handshake: the offered instruction, its PC and register-file read data.
// The master side is decode; the slave side is the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
) ();
    logic                  id_valid;
    logic                  id_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_addr;
    logic [DATA_WIDTH-1:0] rs1_rdata;
    logic [DATA_WIDTH-1:0] rs2_rdata;

    modport master (
        output id_valid,
        output inst,
        output inst_addr,
        output rs1_rdata,
        output rs2_rdata,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  inst,
        input  inst_addr,
        input  rs1_rdata,
        input  rs2_rdata,
        output id_ready
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operands by EX/WB forwarding at capture time and
// inserts bubbles on load-use hazards, holds on downstream stall and clears on flush.
module id_ex_stage #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST  = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    id_ex_stage_if.slave          id_bus,
    input  logic                  ex_reg_we_i,
    input  logic [4:0]            ex_reg_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_reg_wdata_i,
    input  logic                  ex_is_load_i,
    input  logic                  wb_reg_we_i,
    input  logic [4:0]            wb_reg_waddr_i,
    input  logic [DATA_WIDTH-1:0] wb_reg_wdata_i,
    input  logic                  ex_stall_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] op1_o,
    output logic [DATA_WIDTH-1:0] op2_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o
);
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned IMM_W      = 12;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] rs1_res;
    logic [DATA_WIDTH-1:0] rs2_res;
    logic [DATA_WIDTH-1:0] op2_sel;
    logic                  load_use_c;

    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;

    // EX result beats WB result; x0 is hardwired to zero.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_WIDTH-1:0] rdata,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] ex_addr,
        input logic [DATA_WIDTH-1:0] ex_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] res;
        if (addr == '0) begin
            res = '0;
        end else if (ex_we && (ex_addr == addr)) begin
            res = ex_data;
        end else if (wb_we && (wb_addr == addr)) begin
            res = wb_data;
        end else begin
            res = rdata;
        end
        return res;
    endfunction

    // Source decode, operand resolution and hazard detection.
    always_comb begin
        opcode   = id_bus.inst[6:0];
        rs1_addr = id_bus.inst[19:15];
        rs2_addr = id_bus.inst[24:20];
        rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        rs2_used = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        imm_sext = {{(DATA_WIDTH-IMM_W){id_bus.inst[31]}}, id_bus.inst[31:20]};

        rs1_res = resolve(rs1_addr, id_bus.rs1_rdata,
                          ex_reg_we_i, ex_reg_waddr_i, ex_reg_wdata_i,
                          wb_reg_we_i, wb_reg_waddr_i, wb_reg_wdata_i);
        rs2_res = resolve(rs2_addr, id_bus.rs2_rdata,
                          ex_reg_we_i, ex_reg_waddr_i, ex_reg_wdata_i,
                          wb_reg_we_i, wb_reg_waddr_i, wb_reg_wdata_i);

        op2_sel = '0;
        if (rs2_used) begin
            op2_sel = rs2_res;
        end else if (opcode inside {OPC_OP_IMM, OPC_LOAD, OPC_JALR}) begin
            op2_sel = imm_sext;
        end

        load_use_c = id_bus.id_valid & ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != '0) &
                     ((rs1_used & (ex_reg_waddr_i == rs1_addr)) |
                      (rs2_used & (ex_reg_waddr_i == rs2_addr)));
    end

    assign id_bus.id_ready = ~ex_stall_i & ~load_use_c & ~flush_i;

    // Next-state selection: flush > stall (hold) > load-use bubble > capture > bubble.
    always_comb begin
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rs2_data_d  = rs2_data_q;

        if (flush_i || (!ex_stall_i && (load_use_c || !id_bus.id_valid))) begin
            valid_d     = 1'b0;
            inst_d      = NOP_INST;
            inst_addr_d = '0;
            op1_d       = '0;
            op2_d       = '0;
            rs2_data_d  = '0;
        end else if (!ex_stall_i) begin
            valid_d     = 1'b1;
            inst_d      = id_bus.inst;
            inst_addr_d = id_bus.inst_addr;
            op1_d       = rs1_res;
            op2_d       = op2_sel;
            rs2_data_d  = rs2_res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            inst_addr_q <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rs2_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    assign valid_o     = valid_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = inst_addr_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign rs2_data_o  = rs2_data_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked by a scoreboard
// fed from a behavioural model of the pipeline register.
module tb_id_ex_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic           clk = 1'b0;
    logic           rst;
    logic           ex_we, ex_load, wb_we, stall, flush;
    logic [4:0]     ex_waddr, wb_waddr;
    logic [DW-1:0]  ex_wdata, wb_wdata;
    logic           valid_o;
    logic [IW-1:0]  inst_o;
    logic [DW-1:0]  inst_addr_o, op1_o, op2_o, rs2_data_o;

    id_ex_stage_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) id_bus ();

    id_ex_stage #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .id_bus(id_bus),
        .ex_reg_we_i(ex_we), .ex_reg_waddr_i(ex_waddr), .ex_reg_wdata_i(ex_wdata),
        .ex_is_load_i(ex_load),
        .wb_reg_we_i(wb_we), .wb_reg_waddr_i(wb_waddr), .wb_reg_wdata_i(wb_wdata),
        .ex_stall_i(stall), .flush_i(flush),
        .valid_o(valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .op1_o(op1_o), .op2_o(op2_o), .rs2_data_o(rs2_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, id_valid, stall, flush, ex_we, ex_load, wb_we;
        logic [4:0]  ex_waddr, wb_waddr;
        logic [31:0] inst, addr, rs1d, rs2d, ex_wdata, wb_wdata;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] inst, addr, op1, op2, rs2d;
    } ostate_t;

    typedef struct {
        logic    chk_out;
        logic    rdy;
        ostate_t st;
    } item_t;

    item_t   sb_q[$];
    ostate_t m_state;
    logic    m_known = 1'b0;
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic ostate_t invalid_state();
        ostate_t s;
        s.valid = 1'b0; s.inst = NOP; s.addr = 0; s.op1 = 0; s.op2 = 0; s.rs2d = 0;
        return s;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.id_valid = 0; s.stall = 0; s.flush = 0;
        s.ex_we = 0; s.ex_load = 0; s.wb_we = 0; s.ex_waddr = 0; s.wb_waddr = 0;
        s.inst = NOP; s.addr = 0; s.rs1d = 0; s.rs2d = 0; s.ex_wdata = 0; s.wb_wdata = 0;
        return s;
    endfunction

    // Reference view of a register read as seen through the bypass network.
    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (r == 0) return 0;
        if (s.ex_we && s.ex_waddr == r) return s.ex_wdata;
        if (s.wb_we && s.wb_waddr == r) return s.wb_wdata;
        return rf;
    endfunction

    task automatic step(input stim_t s);
        item_t       it;
        logic [6:0]  op;
        logic [4:0]  r1, r2;
        logic        u1, u2, lu;
        ostate_t     nxt;
        @(posedge clk); #1;
        rst = s.rst; stall = s.stall; flush = s.flush;
        ex_we = s.ex_we; ex_load = s.ex_load; ex_waddr = s.ex_waddr; ex_wdata = s.ex_wdata;
        wb_we = s.wb_we; wb_waddr = s.wb_waddr; wb_wdata = s.wb_wdata;
        id_bus.id_valid = s.id_valid; id_bus.inst = s.inst; id_bus.inst_addr = s.addr;
        id_bus.rs1_rdata = s.rs1d; id_bus.rs2_rdata = s.rs2d;

        op = s.inst[6:0]; r1 = s.inst[19:15]; r2 = s.inst[24:20];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        lu = s.id_valid && s.ex_load && s.ex_we && s.ex_waddr != 0 &&
             ((u1 && s.ex_waddr == r1) || (u2 && s.ex_waddr == r2));

        it.chk_out = m_known;
        it.rdy     = !s.stall && !lu && !s.flush;
        it.st      = m_state;
        sb_q.push_back(it);

        nxt = m_state;
        if (s.rst || s.flush) nxt = invalid_state();
        else if (s.stall) nxt = m_state;
        else if (lu || !s.id_valid) nxt = invalid_state();
        else begin
            nxt.valid = 1'b1;
            nxt.inst  = s.inst;
            nxt.addr  = s.addr;
            nxt.op1   = m_read(r1, s.rs1d, s);
            nxt.rs2d  = m_read(r2, s.rs2d, s);
            if (u2) nxt.op2 = nxt.rs2d;
            else if (op == 7'h13 || op == 7'h03 || op == 7'h67) nxt.op2 = 32'($signed(s.inst[31:20]));
            else nxt.op2 = 0;
        end
        m_state = nxt;
        if (s.rst) m_known = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = 7'h33; 1: op = 7'h23; 2: op = 7'h63; 3: op = 7'h13; 4: op = 7'h03;
            5: op = 7'h67; 6: op = 7'h37; 7: op = 7'h17; 8: op = 7'h6F; default: op = 7'h73;
        endcase
        s.inst = $urandom;
        s.inst[6:0]   = op;
        s.inst[19:15] = 5'($urandom_range(0, 3));
        s.inst[24:20] = 5'($urandom_range(0, 3));
        s.addr     = $urandom;
        s.rs1d     = $urandom;
        s.rs2d     = $urandom;
        s.rst      = ($urandom_range(0, 99) < 2);
        s.stall    = ($urandom_range(0, 99) < 20);
        s.flush    = ($urandom_range(0, 99) < 8);
        s.id_valid = ($urandom_range(0, 99) < 85);
        s.ex_we    = ($urandom_range(0, 99) < 60);
        s.ex_load  = ($urandom_range(0, 99) < 30);
        s.wb_we    = ($urandom_range(0, 99) < 60);
        s.ex_waddr = 5'($urandom_range(0, 3));
        s.wb_waddr = 5'($urandom_range(0, 3));
        s.ex_wdata = $urandom;
        s.wb_wdata = $urandom;
        return s;
    endfunction

    // Monitor: at each falling edge compare ready and registered outputs to the scoreboard.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                chk("id_ready", 32'(id_bus.id_ready), 32'(it.rdy));
                if (it.chk_out) begin
                    chk("valid_o", 32'(valid_o), 32'(it.st.valid));
                    chk("inst_o", inst_o, it.st.inst);
                    chk("inst_addr_o", inst_addr_o, it.st.addr);
                    chk("op1_o", op1_o, it.st.op1);
                    chk("op2_o", op2_o, it.st.op2);
                    chk("rs2_data_o", rs2_data_o, it.st.rs2d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, a;
        rst = 1; stall = 0; flush = 0; ex_we = 0; ex_load = 0; wb_we = 0;
        ex_waddr = 0; wb_waddr = 0; ex_wdata = 0; wb_wdata = 0;
        id_bus.id_valid = 0; id_bus.inst = NOP; id_bus.inst_addr = 0;
        id_bus.rs1_rdata = 0; id_bus.rs2_rdata = 0;

        s = idle(); s.rst = 1;
        step(s); step(s);
        chk("reset_valid", 32'(valid_o), 0);
        chk("reset_inst", inst_o, NOP);

        // basic add x3,x1,x2
        a = idle(); a.id_valid = 1; a.inst = 32'h0020_81B3; a.addr = 32'h100; a.rs1d = 5; a.rs2d = 7;
        step(a); step(idle());
        chk("basic_valid", 32'(valid_o), 1);
        chk("basic_inst", inst_o, 32'h0020_81B3);
        chk("basic_op1", op1_o, 5);
        chk("basic_op2", op2_o, 7);

        // forwarding priority
        s = a; s.rs1d = 0; s.rs2d = 0;
        s.ex_we = 1; s.ex_waddr = 1; s.ex_wdata = 32'h11;
        s.wb_we = 1; s.wb_waddr = 2; s.wb_wdata = 32'h33;
        step(s);
        s.wb_waddr = 1; s.wb_wdata = 32'h22;
        step(s);
        chk("fwd_ex_op1", op1_o, 32'h11);
        chk("fwd_wb_op2", op2_o, 32'h33);
        s = idle(); s.id_valid = 1; s.inst = 32'h0020_01B3; s.rs1d = 32'h55;
        s.ex_we = 1; s.ex_waddr = 0; s.ex_wdata = 32'h99; s.wb_we = 1; s.wb_waddr = 0; s.wb_wdata = 32'h77;
        step(s);
        chk("fwd_ex_over_wb", op1_o, 32'h11);
        step(idle());
        chk("fwd_x0_op1", op1_o, 0);

        // load-use bubble then WB forward
        s = a; s.rs1d = 0; s.ex_we = 1; s.ex_load = 1; s.ex_waddr = 1; s.ex_wdata = 32'hDEAD;
        step(s);
        s = a; s.rs1d = 0; s.wb_we = 1; s.wb_waddr = 1; s.wb_wdata = 32'hAB;
        step(s);
        chk("lu_bubble_valid", 32'(valid_o), 0);
        chk("lu_bubble_inst", inst_o, NOP);
        step(idle());
        chk("lu_wb_op1", op1_o, 32'hAB);
        chk("lu_wb_valid", 32'(valid_o), 1);

        // stall three cycles then flush while stalled
        s = a; s.rs1d = 32'h1234; step(s);
        s = idle(); s.stall = 1; s.id_valid = 1; s.inst = 32'hFFC3_0293;
        step(s); step(s); step(s);
        chk("stall_hold_op1", op1_o, 32'h1234);
        s.flush = 1; step(s);
        step(idle());
        chk("flush_valid", 32'(valid_o), 0);
        chk("flush_inst", inst_o, NOP);

        // addi x5,x6,-4 with rs2 field (x28) forwarded from EX
        s = idle(); s.id_valid = 1; s.inst = 32'hFFC3_0293; s.rs1d = 10; s.rs2d = 32'h5555;
        s.ex_we = 1; s.ex_waddr = 28; s.ex_wdata = 32'h1C1C;
        step(s); step(idle());
        chk("imm_op1", op1_o, 10);
        chk("imm_op2", op2_o, 32'hFFFF_FFFC);
        chk("imm_rs2_data", rs2_data_o, 32'h1C1C);

        // reset while holding a valid instruction
        step(a);
        s = idle(); s.stall = 1; step(s);
        s.rst = 1; step(s);
        step(idle());
        chk("rst_mid_valid", 32'(valid_o), 0);
        chk("rst_mid_inst", inst_o, NOP);
        chk("rst_mid_addr", inst_addr_o, 0);
        chk("rst_mid_op1", op1_o, 0);
        chk("rst_mid_op2", op2_o, 0);
        chk("rst_mid_rs2", rs2_data_o, 0);

        for (int i = 0; i < 400; i++) step(rand_stim());
        step(idle());
        @(negedge clk);
        @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
